// File: rtl/rr_arbiter8_pkg.sv
// rtl/rr_arbiter8_pkg.sv - shared constants, state encoding and round-robin pick for rr_arbiter8
package rr_arbiter8_pkg;

    localparam int N_REQ        = 8;
    localparam int IDX_W        = 3;
    localparam int MAX_HOLD_DEF = 15;
    localparam int HOLD_W_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // First requester at or after ptr, wrapping modulo N_REQ through the IDX_W-bit add
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] result;
        logic             found;
        result = ptr;
        found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand]) begin
                result = cand;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// rtl/rr_arbiter8_if.sv - request/grant bundle between clients and rr_arbiter8
interface rr_arbiter8_if;
    import rr_arbiter8_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             timeout;

    modport master (
        output req, done,
        input  grant, grant_idx, grant_valid, timeout
    );

    modport slave (
        input  req, done,
        output grant, grant_idx, grant_valid, timeout
    );

endinterface

// File: rtl/decorder3to8.sv
// rtl/decorder3to8.sv - 3-to-8 one-hot decoder
module decorder3to8 (
    input  logic [2:0] A,
    output logic [7:0] Y
);

    assign Y = 8'b0000_0001 << A;

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with one dead cycle between owners and bounded hold
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int HOLD_W   = HOLD_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter8_if.slave  bus
);

    state_t            state, state_n;
    logic [IDX_W-1:0]  ptr, ptr_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [HOLD_W-1:0] hold, hold_n;
    logic              valid, valid_n;
    logic              tmo, tmo_n;
    logic              owner_req;
    logic              hold_lim;
    logic [N_REQ-1:0]  raw_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            idx   <= '0;
            hold  <= '0;
            valid <= 1'b0;
            tmo   <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            idx   <= idx_n;
            hold  <= hold_n;
            valid <= valid_n;
            tmo   <= tmo_n;
        end
    end

    assign owner_req = bus.req[idx];
    assign hold_lim  = (hold == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idx_n   = idx;
        hold_n  = hold;
        valid_n = valid;
        tmo_n   = 1'b0;
        case (state)
            ST_IDLE, ST_GAP: begin
                if (|bus.req) begin
                    idx_n   = rr_pick(bus.req, ptr);
                    valid_n = 1'b1;
                    hold_n  = '0;
                    state_n = ST_GRANT;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (bus.done || !owner_req || hold_lim) begin
                    valid_n = 1'b0;
                    ptr_n   = idx + 1'b1;
                    state_n = ST_GAP;
                    // A voluntary release on the limit cycle is not reported as a timeout
                    tmo_n   = hold_lim && !bus.done && owner_req;
                end else begin
                    hold_n  = hold + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    decorder3to8 u_dec (
        .A (idx),
        .Y (raw_grant)
    );

    assign bus.grant       = raw_grant & {N_REQ{valid}};
    assign bus.grant_idx   = idx;
    assign bus.grant_valid = valid;
    assign bus.timeout     = tmo;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed self-checking bench for rr_arbiter8
module tb_rr_arbiter8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rr_arbiter8_if bus ();

    rr_arbiter8 #(.MAX_HOLD(15), .HOLD_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [2:0] idx;
        logic       valid;
        logic [7:0] grant;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic add_vec(input logic [7:0] req, input logic done, input logic [2:0] idx,
                           input logic valid, input logic [7:0] grant);
        vec_t v;
        v.req   = req;
        v.done  = done;
        v.idx   = idx;
        v.valid = valid;
        v.grant = grant;
        v.tmo   = 1'b0;
        vecs.push_back(v);
    endtask

    // Each grant: two held cycles, then done releases into the gap
    task automatic add_grant(input logic [7:0] req, input logic [2:0] idx, input logic [7:0] onehot);
        add_vec(req, 1'b0, idx, 1'b1, onehot);
        add_vec(req, 1'b0, idx, 1'b1, onehot);
        add_vec(req, 1'b1, idx, 1'b0, 8'h00);
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            bus.req  = vecs[i].req;
            bus.done = vecs[i].done;
            tick();
            check($sformatf("vec%0d grant", i),     bus.grant,       vecs[i].grant);
            check($sformatf("vec%0d grant_idx", i), bus.grant_idx,   vecs[i].idx);
            check($sformatf("vec%0d valid", i),     bus.grant_valid, vecs[i].valid);
            check($sformatf("vec%0d timeout", i),   bus.timeout,     vecs[i].tmo);
            check($sformatf("vec%0d onehot", i),    $countones(bus.grant), bus.grant_valid ? 1 : 0);
        end
    endtask

    initial begin
        bus.req  = 8'h00;
        bus.done = 1'b0;

        add_grant(8'hFF, 3'd0, 8'h01);
        add_grant(8'hFF, 3'd1, 8'h02);
        add_grant(8'hFF, 3'd2, 8'h04);
        add_grant(8'hFF, 3'd3, 8'h08);
        add_grant(8'hFF, 3'd4, 8'h10);
        add_grant(8'hFF, 3'd5, 8'h20);
        add_grant(8'hFF, 3'd6, 8'h40);
        add_grant(8'hFF, 3'd7, 8'h80);
        add_grant(8'hFF, 3'd0, 8'h01);
        add_grant(8'h84, 3'd2, 8'h04);
        add_grant(8'h84, 3'd7, 8'h80);
        add_grant(8'h84, 3'd2, 8'h04);

        #1;
        check("rst grant",     bus.grant,       8'h00);
        check("rst grant_idx", bus.grant_idx,   3'd0);
        check("rst valid",     bus.grant_valid, 1'b0);
        check("rst timeout",   bus.timeout,     1'b0);

        reset_dut();
        run_table(0, 27);
        reset_dut();
        run_table(27, 36);

        // Sole requester held past the limit
        reset_dut();
        bus.req = 8'h20;
        tick();
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.grant == 8'h20) cnt++;
            else break;
            tick();
        end
        check("hold cycles",      cnt,             15);
        check("timeout pulse",    bus.timeout,     1'b1);
        check("timeout gap",      bus.grant,       8'h00);
        tick();
        check("timeout regrant",  bus.grant,       8'h20);
        check("timeout one-shot", bus.timeout,     1'b0);

        // done on the limit cycle wins over timeout
        reset_dut();
        bus.req = 8'h20;
        tick();
        repeat (14) tick();
        check("limit held",       bus.grant,       8'h20);
        bus.done = 1'b1;
        tick();
        check("limit done valid", bus.grant_valid, 1'b0);
        check("limit done tmo",   bus.timeout,     1'b0);
        bus.done = 1'b0;
        tick();
        check("limit done regrant", bus.grant,     8'h20);
        check("limit done tmo2",  bus.timeout,     1'b0);

        // Owner withdraws; pointer must move past it
        reset_dut();
        bus.req = 8'h48;
        tick();
        repeat (3) tick();
        check("drop owner",       bus.grant,       8'h08);
        bus.req = 8'h41;
        tick();
        check("drop valid",       bus.grant_valid, 1'b0);
        check("drop timeout",     bus.timeout,     1'b0);
        check("drop idx hold",    bus.grant_idx,   3'd3);
        tick();
        check("drop next grant",  bus.grant,       8'h40);
        check("drop next idx",    bus.grant_idx,   3'd6);

        // Asynchronous reset in the middle of a grant
        reset_dut();
        bus.req = 8'h81;
        tick();
        check("ar first",         bus.grant,       8'h01);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        check("ar second",        bus.grant,       8'h80);
        #2 rst = 1'b1;
        #1;
        check("ar grant",         bus.grant,       8'h00);
        check("ar valid",         bus.grant_valid, 1'b0);
        check("ar idx",           bus.grant_idx,   3'd0);
        #2 rst = 1'b0;
        bus.req = 8'h81;
        tick();
        check("ar regrant",       bus.grant,       8'h01);
        check("ar regrant idx",   bus.grant_idx,   3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
